// File: rtl/game_flow_pkg.sv
// Shared definitions for the breakout game flow controller and the renderer status display.
// Holds the GAME_STATE encoding and the default block count.
package game_flow_pkg;

  localparam int unsigned NumBlocksDefault = 72;

  // Encoding is visible on the game_state port and decoded by the renderer.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StLost  = 3'd3,
    StWon   = 3'd4
  } game_state_e;

endpackage

// File: rtl/game_flow_controller_block_counter.sv
// block_counter: serially scans the block-alive vector one bit per cycle and latches the
// alive count once per full pass (every NUM_BLOCKS cycles).
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   restart      reload blocks_left to NUM_BLOCKS and restart the scan at index 0
//   block_state  1 = block alive
//   blocks_left  latched alive-block count
module block_counter
  import game_flow_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = NumBlocksDefault,
  localparam int unsigned CountW = $clog2(NUM_BLOCKS + 1),
  localparam int unsigned IdxW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [NUM_BLOCKS-1:0] block_state,
  output logic [CountW-1:0]     blocks_left
);

  logic [IdxW-1:0]   idx_q;
  logic [CountW-1:0] acc_q;
  logic [CountW-1:0] blocks_left_q;
  logic              cur_bit;
  logic              last_idx;
  logic [CountW-1:0] acc_sum;

  always_comb begin
    cur_bit  = block_state[idx_q];
    last_idx = (idx_q == IdxW'(NUM_BLOCKS - 1));
    acc_sum  = acc_q + CountW'(cur_bit);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      idx_q         <= '0;
      acc_q         <= '0;
      blocks_left_q <= CountW'(NUM_BLOCKS);
    end else if (last_idx) begin
      // Final bit of the pass folds straight into the published count.
      blocks_left_q <= acc_sum;
      acc_q         <= '0;
      idx_q         <= '0;
    end else begin
      acc_q <= acc_sum;
      idx_q <= idx_q + IdxW'(1);
    end
  end

  assign blocks_left = blocks_left_q;

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: game state machine (IDLE/SERVE/PLAY/LOST/WON), lives, serve
// auto-launch timer and physics update pacing for the breakout game.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   frame_rendered    one-cycle pulse per rendered frame
//   btn_release       launch/restart button level (already synchronised)
//   sw_pause          freezes physics updates and the serve timer
//   sw_ignore_death   ball loss costs no life
//   ball_lost         one-cycle pulse when the ball passes the paddle
//   block_state       1 = block alive
//   start_update      one-cycle physics update pulse
//   physics_reset     one-cycle pulse restoring paddle, ball and blocks
//   ball_held         ball sits on the paddle
//   lives             remaining lives
//   blocks_left       latched alive-block count
//   game_state        current state encoding
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = NumBlocksDefault,
  parameter int unsigned NUM_LIVES = 3,
  parameter int unsigned SERVE_TIMEOUT_FRAMES = 180,
  localparam int unsigned CountW = $clog2(NUM_BLOCKS + 1),
  localparam int unsigned TimerW = $clog2(SERVE_TIMEOUT_FRAMES + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_rendered,
  input  logic                  btn_release,
  input  logic                  sw_pause,
  input  logic                  sw_ignore_death,
  input  logic                  ball_lost,
  input  logic [NUM_BLOCKS-1:0] block_state,
  output logic                  start_update,
  output logic                  physics_reset,
  output logic                  ball_held,
  output logic [3:0]            lives,
  output logic [CountW-1:0]     blocks_left,
  output logic [2:0]            game_state
);

  game_state_e       state_q, state_d;
  logic [3:0]        lives_q, lives_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [TimerW-1:0] timer_inc;
  logic              btn_q;
  logic              start_update_q, start_update_d;
  logic              btn_edge;
  logic              loss;
  logic              frame_tick;
  logic              timeout_hit;
  logic              restart;

  block_counter #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_block_counter (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .block_state (block_state),
    .blocks_left (blocks_left)
  );

  always_comb begin
    btn_edge    = btn_release & ~btn_q;
    loss        = ball_lost & ~sw_ignore_death;
    frame_tick  = frame_rendered & ~sw_pause;
    timer_inc   = timer_q + TimerW'(1);
    timeout_hit = (SERVE_TIMEOUT_FRAMES != 0) && frame_tick &&
                  (timer_inc == TimerW'(SERVE_TIMEOUT_FRAMES));

    state_d        = state_q;
    lives_d        = lives_q;
    restart        = 1'b0;
    start_update_d = frame_tick && ((state_q == StServe) || (state_q == StPlay));

    // Held at zero outside SERVE so every SERVE entry starts a fresh count.
    timer_d = '0;
    if (state_q == StServe) begin
      timer_d = frame_tick ? timer_inc : timer_q;
    end

    case (state_q)
      StIdle: begin
        if (btn_edge) state_d = StServe;
      end
      StServe: begin
        if (btn_edge || timeout_hit) state_d = StPlay;
      end
      StPlay: begin
        // A loss takes priority over a simultaneous win.
        if (loss) begin
          lives_d = lives_q - 4'd1;
          state_d = (lives_q == 4'd1) ? StLost : StServe;
        end else if (blocks_left == '0) begin
          state_d = StWon;
        end
      end
      StLost, StWon: begin
        if (btn_edge) begin
          state_d = StIdle;
          restart = 1'b1;
          lives_d = 4'(NUM_LIVES);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      lives_q        <= 4'(NUM_LIVES);
      timer_q        <= '0;
      btn_q          <= 1'b0;
      start_update_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      timer_q        <= timer_d;
      btn_q          <= btn_release;
      start_update_q <= start_update_d;
    end
  end

  assign start_update  = start_update_q;
  assign physics_reset = reset | restart;
  assign ball_held     = (state_q == StIdle) || (state_q == StServe);
  assign lives         = lives_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

  localparam int NB = 72;
  localparam int NL = 3;
  localparam int TO = 4;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, LOST = 3, WON = 4;

  logic          clk = 1'b0;
  logic          reset, frame_rendered, btn_release, sw_pause, sw_ignore_death, ball_lost;
  logic [NB-1:0] block_state;
  logic          start_update, physics_reset, ball_held;
  logic [3:0]    lives;
  logic [6:0]    blocks_left;
  logic [2:0]    game_state;

  game_flow_controller #(
    .NUM_BLOCKS          (NB),
    .NUM_LIVES           (NL),
    .SERVE_TIMEOUT_FRAMES(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_rendered (frame_rendered),
    .btn_release    (btn_release),
    .sw_pause       (sw_pause),
    .sw_ignore_death(sw_ignore_death),
    .ball_lost      (ball_lost),
    .block_state    (block_state),
    .start_update   (start_update),
    .physics_reset  (physics_reset),
    .ball_held      (ball_held),
    .lives          (lives),
    .blocks_left    (blocks_left),
    .game_state     (game_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game rules evaluated once per clock from the sampled inputs.
  int m_state, m_lives, m_bl, m_phase, m_timer;
  bit m_prev, m_su;
  bit m_bits[NB];

  always @(posedge clk) begin : p_model
    int  nstate, nlives;
    bit  edge_ev, restart_ev, tick_ev;
    if (reset) begin
      m_state = IDLE; m_lives = NL; m_bl = NB; m_phase = 0; m_timer = 0;
      m_prev = 0; m_su = 0;
    end else begin
      edge_ev    = btn_release && !m_prev;
      tick_ev    = frame_rendered && !sw_pause;
      restart_ev = 0;
      nstate     = m_state;
      nlives     = m_lives;
      m_su       = tick_ev && (m_state == SERVE || m_state == PLAY);
      if (m_state == IDLE) begin
        if (edge_ev) nstate = SERVE;
      end else if (m_state == SERVE) begin
        if (tick_ev) m_timer++;
        if (edge_ev || (tick_ev && m_timer == TO)) nstate = PLAY;
      end else if (m_state == PLAY) begin
        if (ball_lost && !sw_ignore_death) begin
          nlives = m_lives - 1;
          nstate = (nlives == 0) ? LOST : SERVE;
        end else if (m_bl == 0) begin
          nstate = WON;
        end
      end else if (edge_ev) begin
        nstate = IDLE; restart_ev = 1; nlives = NL;
      end
      if (restart_ev) begin
        m_bl = NB; m_phase = 0;
      end else begin
        m_bits[m_phase] = block_state[m_phase];
        if (m_phase == NB - 1) begin
          m_bl = 0;
          foreach (m_bits[k]) m_bl += int'(m_bits[k]);
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      if (nstate == SERVE && m_state != SERVE) m_timer = 0;
      m_state = nstate;
      m_lives = nlives;
      m_prev  = btn_release;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(game_state), m_state);
      chk("lives", int'(lives), m_lives);
      chk("blocks_left", int'(blocks_left), m_bl);
      chk("start_update", int'(start_update), int'(m_su));
      chk("ball_held", int'(ball_held), int'(m_state == IDLE || m_state == SERVE));
      chk("physics_reset", int'(physics_reset),
          int'(reset || (m_state >= LOST && btn_release && !m_prev)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_btn();
    btn_release = 1'b1; tick();
    btn_release = 1'b0; tick();
  endtask

  task automatic pulse_loss();
    ball_lost = 1'b1; tick();
    ball_lost = 1'b0;
  endtask

  logic [95:0] rnd;
  bit          zero_mode;

  initial begin
    reset = 1'b1; frame_rendered = 0; btn_release = 0; sw_pause = 0;
    sw_ignore_death = 0; ball_lost = 0; block_state = {NB{1'b1}};
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_phys", int'(physics_reset), 1);
    chk("rst_state", int'(game_state), IDLE);
    chk("rst_lives", int'(lives), 3);
    chk("rst_blocks", int'(blocks_left), 72);
    chk("rst_su", int'(start_update), 0);
    reset = 1'b0; #1;
    chk("rst_phys_low", int'(physics_reset), 0);
    tick();

    // Serve with three frames: one update per frame, one cycle late.
    pulse_btn();
    chk("serve_state", int'(game_state), SERVE);
    repeat (3) begin
      frame_rendered = 1'b1; tick();
      chk("su_after_frame", int'(start_update), 1);
      frame_rendered = 1'b0; tick();
      chk("su_one_cycle", int'(start_update), 0);
    end
    chk("serve_held", int'(ball_held), 1);
    chk("serve_stays", int'(game_state), SERVE);

    pulse_btn();
    chk("play_state", int'(game_state), PLAY);

    // Ignored deaths, then three counted losses.
    sw_ignore_death = 1'b1;
    repeat (3) begin pulse_loss(); tick(); end
    chk("ignore_lives", int'(lives), 3);
    chk("ignore_state", int'(game_state), PLAY);
    sw_ignore_death = 1'b0;
    pulse_loss();
    chk("loss1_lives", int'(lives), 2);
    chk("loss1_state", int'(game_state), SERVE);
    pulse_btn(); pulse_loss();
    chk("loss2_lives", int'(lives), 1);
    pulse_btn(); pulse_loss();
    chk("loss3_lives", int'(lives), 0);
    chk("loss3_state", int'(game_state), LOST);

    btn_release = 1'b1; #1;
    chk("lost_phys", int'(physics_reset), 1);
    tick();
    chk("lost_idle", int'(game_state), IDLE);
    chk("lost_reload_lives", int'(lives), 3);
    chk("lost_phys_low", int'(physics_reset), 0);
    btn_release = 1'b0; tick();

    // Paused serve then timeout launch.
    pulse_btn();
    sw_pause = 1'b1;
    repeat (10) begin
      frame_rendered = 1'b1; tick();
      chk("paused_su", int'(start_update), 0);
      frame_rendered = 1'b0; tick();
    end
    sw_pause = 1'b0;
    repeat (3) begin frame_rendered = 1'b1; tick(); frame_rendered = 1'b0; tick(); end
    chk("timeout_not_yet", int'(game_state), SERVE);
    frame_rendered = 1'b1; tick(); frame_rendered = 1'b0;
    chk("timeout_play", int'(game_state), PLAY);

    // Clear all blocks: win, then restart.
    block_state = '0;
    for (int i = 0; i < 2 * NB && blocks_left != 0; i++) tick();
    chk("blocks_zero", int'(blocks_left), 0);
    tick();
    chk("won_state", int'(game_state), WON);
    frame_rendered = 1'b1; tick(); frame_rendered = 1'b0;
    chk("won_su", int'(start_update), 0);
    btn_release = 1'b1; #1;
    chk("won_phys", int'(physics_reset), 1);
    tick();
    chk("won_idle", int'(game_state), IDLE);
    chk("won_lives", int'(lives), 3);
    chk("won_blocks", int'(blocks_left), 72);
    btn_release = 1'b0; block_state = {NB{1'b1}}; tick();

    // Loss and win in the same cycle with two lives left.
    pulse_btn(); pulse_btn();
    pulse_loss(); pulse_btn();
    chk("both_pre_lives", int'(lives), 2);
    block_state = '0;
    for (int i = 0; i < 2 * NB && m_bl != 0; i++) tick();
    ball_lost = 1'b1; tick(); ball_lost = 1'b0;
    chk("both_state", int'(game_state), SERVE);
    chk("both_lives", int'(lives), 1);
    block_state = {NB{1'b1}};

    // Randomised play against the model.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    zero_mode = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 15) == 0) btn_release = ~btn_release;
      frame_rendered = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) sw_pause = ~sw_pause;
      if ($urandom_range(0, 99) == 0) sw_ignore_death = ~sw_ignore_death;
      ball_lost = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) zero_mode = ~zero_mode;
      rnd = {$urandom, $urandom, $urandom};
      block_state = zero_mode ? '0 : (rnd[NB-1:0] | {rnd[NB-1:8], 8'h00});
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter NUM_BLOCKS, default 72, number of block-state bits scanned.
REQ-002 Parameter NUM_LIVES, default 3, lives loaded at game start; range 1..15.
REQ-003 Parameter SERVE_TIMEOUT_FRAMES, default 180, frames in SERVE before auto-launch; 0 disables auto-launch.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  system clock.
REQ-006 RESET  in  1  synchronous active-high reset.
REQ-007 FRAME_RENDERED  in  1  one-cycle pulse per rendered frame.
REQ-008 BTN_RELEASE  in  1  launch/restart button, already synchronised, level.
REQ-009 SW_PAUSE  in  1  level; freezes physics updates and serve timer.
REQ-010 SW_IGNORE_DEATH  in  1  level; ball loss does not cost a life.
REQ-011 BALL_LOST  in  1  one-cycle pulse from physics when ball passes paddle.
REQ-012 BLOCK_STATE  in  NUM_BLOCKS  1 = block alive.
REQ-013 START_UPDATE  out  1  one-cycle pulse to physics.
REQ-014 PHYSICS_RESET  out  1  one-cycle pulse restoring paddle, ball and all blocks.
REQ-015 BALL_HELD  out  1  ball sits on paddle (high in IDLE and SERVE).
REQ-016 LIVES  out  4  remaining lives.
REQ-017 BLOCKS_LEFT  out  clog2(NUM_BLOCKS+1)  latched alive-block count.
REQ-018 GAME_STATE  out  3  IDLE=0, SERVE=1, PLAY=2, LOST=3, WON=4.

Function
REQ-019 Button edge: BTN_EDGE = BTN_RELEASE & !previous registered BTN_RELEASE.
REQ-020 FSM: IDLE -BTN_EDGE-> SERVE; SERVE -BTN_EDGE or timeout-> PLAY; PLAY -BALL_LOST, loss counted, LIVES==1-> LOST; PLAY -BALL_LOST, loss counted, LIVES>1-> SERVE; PLAY -BLOCKS_LEFT==0-> WON; LOST/WON -BTN_EDGE-> IDLE.
REQ-021 Loss counted = BALL_LOST & !SW_IGNORE_DEATH, in PLAY only; decrements LIVES by 1 in the same transition; BALL_LOST in other states ignored.
REQ-022 BALL_LOST and BLOCKS_LEFT==0 in the same PLAY cycle: loss processed, win ignored that cycle.
REQ-023 START_UPDATE registered: high one cycle after FRAME_RENDERED iff state in {SERVE, PLAY} and !SW_PAUSE; never high in IDLE, LOST, WON.
REQ-024 Serve timer: cleared on SERVE entry; increments on FRAME_RENDERED while in SERVE and !SW_PAUSE; reaching SERVE_TIMEOUT_FRAMES (nonzero) forces PLAY; BTN_EDGE wins if simultaneous (same result).
REQ-025 LOST/WON -> IDLE transition: PHYSICS_RESET pulses for one cycle, LIVES reloads NUM_LIVES, BLOCKS_LEFT reloads NUM_BLOCKS, scan restarts at index 0 the following cycle.
REQ-026 Block scan: index walks 0..NUM_BLOCKS-1, one bit per cycle, accumulating alive bits; on last index BLOCKS_LEFT <= accumulator + current bit, accumulator cleared, index wraps to 0; refresh every NUM_BLOCKS cycles.
REQ-027 SW_PAUSE does not block FSM transitions driven by BTN_EDGE or BALL_LOST.

Reset
REQ-028 RESET SHALL force: state IDLE, LIVES=NUM_LIVES, BLOCKS_LEFT=NUM_BLOCKS, scan index/accumulator 0, serve timer 0, button history 0, START_UPDATE 0, PHYSICS_RESET 1 for the reset cycle(s), then 0.
REQ-029 RESET asserted mid-game overrides all events in the same cycle.

Structure
REQ-030 Shared package SHALL hold the GAME_STATE encodings and NUM_BLOCKS default, shared with the renderer (status display).
REQ-031 Block scanner SHALL be one sub-module, block_counter (BLOCK_STATE in, BLOCKS_LEFT out, restart in); FSM and timer remain in the top.

Verification
REQ-032 Reset, BTN_EDGE, 3 FRAME_RENDERED -> GAME_STATE 0->1, three START_UPDATE pulses each 1 cycle after its frame pulse, BALL_HELD=1.
REQ-033 PLAY, three BALL_LOST pulses with SW_IGNORE_DEATH=0 -> LIVES 3,2,1,0 sequence ends in LOST; with SW_IGNORE_DEATH=1 LIVES stays 3, state stays PLAY.
REQ-034 SERVE, SERVE_TIMEOUT_FRAMES=4, SW_PAUSE=1 for 10 frames then 0 -> no START_UPDATE while paused, PLAY after 4th unpaused frame.
REQ-035 PLAY, BLOCK_STATE driven to 0 -> BLOCKS_LEFT=0 within 2*NUM_BLOCKS cycles, then WON, START_UPDATE suppressed; BTN_EDGE -> IDLE, PHYSICS_RESET one pulse, LIVES=3, BLOCKS_LEFT=72.
REQ-036 Same-cycle BALL_LOST and BLOCKS_LEFT==0 with LIVES=2 -> SERVE, LIVES=1.
